// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory request/response bundle for the fetch stage
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, fetch FSM, hold buffer and IF/ID register
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fetch_stage_if.master        imem,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc,
    output logic [31:0]          instruction,
    output logic [31:0]          pc_plus4,
    output logic                 if_valid
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] hold_buf;
    logic        req_q;

    logic        delivered;
    logic        load_word;
    logic [31:0] word;
    logic [31:0] pc_next4;

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc;

    // A word only counts while a request is outstanding; rdata is ignored otherwise.
    assign pc_next4  = pc + 32'd4;
    assign delivered = (state == FETCH) && imem.imem_ready;
    assign load_word = !redirect && !stall && (delivered || (state == HOLD));
    assign word      = (state == HOLD) ? hold_buf : imem.imem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            state       <= IDLE;
            req_q       <= 1'b0;
            hold_buf    <= 32'h0;
            instruction <= 32'h0;
            pc_plus4    <= 32'h0;
            if_valid    <= 1'b0;
        end else begin
            // IF/ID: flush beats stall; stall holds; otherwise load the word or a bubble.
            if (flush || (!stall && !load_word)) begin
                instruction <= 32'h0;
                pc_plus4    <= 32'h0;
                if_valid    <= 1'b0;
            end else if (load_word) begin
                instruction <= word;
                pc_plus4    <= pc_next4;
                if_valid    <= 1'b1;
            end

            if (redirect) begin
                pc       <= {redirect_pc[31:2], 2'b00};
                state    <= FETCH;
                req_q    <= 1'b1;
                hold_buf <= 32'h0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= FETCH;
                        req_q <= 1'b1;
                    end
                    FETCH: begin
                        if (imem.imem_ready) begin
                            if (stall) begin
                                hold_buf <= imem.imem_rdata;
                                state    <= HOLD;
                                req_q    <= 1'b0;
                            end else begin
                                pc <= pc_next4;
                            end
                        end
                    end
                    HOLD: begin
                        if (!stall) begin
                            pc    <= pc_next4;
                            state <= FETCH;
                            req_q <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        req_q <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
